// File: rtl/game_pkg.sv
// game_pkg: shared display constants, coordinate type, game state enumeration and clamp helper.
package game_pkg;
   localparam int CW     = 12;
   localparam int DISP_W = 640;
   localparam int DISP_H = 480;
   typedef logic [CW-1:0] coord_t;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, WRAP} state_e;
   function automatic coord_t clamp(input coord_t v, input coord_t lo, input coord_t hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction
endpackage

// File: rtl/scroll_pipe_if.sv
// scroll_pipe_if: groups the pipe control strobes and geometry outputs.
// Ports: animate/run (controller -> pipe), x1/x2/gap_y1/gap_y2/pass/active (pipe -> controller).
interface scroll_pipe_if;
   import game_pkg::*;
   logic   animate;
   logic   run;
   coord_t x1;
   coord_t x2;
   coord_t gap_y1;
   coord_t gap_y2;
   logic   pass;
   logic   active;
   modport master (output animate, run, input x1, x2, gap_y1, gap_y2, pass, active);
   modport slave  (input animate, run, output x1, x2, gap_y1, gap_y2, pass, active);
endinterface

// File: rtl/scroll_pipe_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clock out of reset.
// Ports: i_clk clock, i_rst_n sync active-low reset (loads SEED), o_q current LFSR state.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [15:0] o_q
);
   logic [15:0] q_q;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) q_q <= SEED;
      else          q_q <= {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
   end
   assign o_q = q_q;
endmodule

// File: rtl/scroll_pipe.sv
// scroll_pipe: scrolling pipe obstacle with gap, score pulse and wrap-around.
// Ports: i_clk clock, i_rst_n sync active-low reset, i_animate frame strobe, i_run motion enable,
//        o_x1/o_x2 clipped left/right edges, o_gap_y1/o_gap_y2 gap top/bottom,
//        o_pass score pulse, o_active high while running.
// Macro SCROLL_PIPE_RANDOM_GAP_EN: new gap centre on each wrap comes from an LFSR
// instead of reloading IY.
module scroll_pipe
   import game_pkg::*;
#(
   parameter int          X_SIZE   = 40,
   parameter int          GAP_SIZE = 60,
   parameter int          IX       = 720,
   parameter int          IY       = 240,
   parameter int          D_WIDTH  = DISP_W,
   parameter int          D_HEIGHT = DISP_H,
   parameter int          SPEED    = 2,
   parameter int          SCORE_X  = 160,
   parameter int          MARGIN   = 20,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_animate,
   input  logic   i_run,
   output coord_t o_x1,
   output coord_t o_x2,
   output coord_t o_gap_y1,
   output coord_t o_gap_y2,
   output logic   o_pass,
   output logic   o_active
);
   localparam coord_t W2    = coord_t'(2 * X_SIZE);
   localparam coord_t DW    = coord_t'(D_WIDTH);
   localparam coord_t XWRAP = coord_t'(D_WIDTH + 2 * X_SIZE);
   localparam coord_t SPD   = coord_t'(SPEED);
   localparam coord_t SX    = coord_t'(SCORE_X);
   localparam coord_t GS    = coord_t'(GAP_SIZE);
   localparam coord_t GY_LO = coord_t'(GAP_SIZE + MARGIN);
   localparam coord_t GY_HI = coord_t'(D_HEIGHT - GAP_SIZE - MARGIN);
   if (D_WIDTH + 2 * X_SIZE >= 4096 || SPEED >= 2 * X_SIZE) begin : g_bad_geom
      $error("scroll_pipe: geometry does not fit 12-bit arithmetic");
   end
   if (GY_LO > GY_HI || SEED == 16'h0) begin : g_bad_gap
      $error("scroll_pipe: empty gap range or zero LFSR seed");
   end
   state_e state_q, state_d;
   coord_t xr_q, xr_d, gy_q, gy_d, xr_mv, new_gy;
   logic   pass_q, pass_d, move, at_wrap;
`ifdef SCROLL_PIPE_RANDOM_GAP_EN
   logic [15:0] lfsr;
   lfsr16 #(.SEED(SEED)) u_lfsr (.i_clk(i_clk), .i_rst_n(i_rst_n), .o_q(lfsr));
   // Mask keeps bits [8:0]; casting the masked full word keeps every LFSR bit referenced.
   assign new_gy = clamp(coord_t'(lfsr & 16'h01FF), GY_LO, GY_HI);
`else
   assign new_gy = coord_t'(IY);
`endif
   always_comb begin
      move    = (state_q == RUN) && i_animate && i_run;
      at_wrap = xr_q <= SPD;
      xr_mv   = xr_q - SPD;
      state_d = state_q;
      if (state_q == WRAP)                          state_d = RUN;
      else if (state_q == RUN && !i_run)            state_d = PAUSE;
      else if (state_q == RUN && move && at_wrap)   state_d = WRAP;
      else if (state_q != RUN && i_run)             state_d = RUN;
      xr_d   = !move ? xr_q : (at_wrap ? XWRAP : xr_mv);
      // A wrapping move never scores, even though xr jumps across SCORE_X.
      pass_d = move && !at_wrap && xr_q >= SX && xr_mv < SX;
      gy_d   = (state_q == WRAP) ? new_gy : gy_q;
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         xr_q    <= coord_t'(IX);
         gy_q    <= coord_t'(IY);
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         gy_q    <= gy_d;
         pass_q  <= pass_d;
      end
   end
   assign o_x1     = (xr_q < W2) ? '0 : ((xr_q - W2 > DW) ? DW : xr_q - W2);
   assign o_x2     = (xr_q > DW) ? DW : xr_q;
   assign o_gap_y1 = gy_q - GS;
   assign o_gap_y2 = gy_q + GS;
   assign o_pass   = pass_q;
   assign o_active = state_q == RUN;
endmodule

// File: tb/tb_scroll_pipe.sv
// tb_scroll_pipe: vector table, directed sequences and random stimulus against a behavioural pipe model.
module tb_scroll_pipe;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_WRAP = 3;
`ifdef SCROLL_PIPE_RANDOM_GAP_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   scroll_pipe_if sp0 ();
   scroll_pipe_if sp1 ();
   scroll_pipe u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_animate(sp0.animate), .i_run(sp0.run),
      .o_x1(sp0.x1), .o_x2(sp0.x2), .o_gap_y1(sp0.gap_y1), .o_gap_y2(sp0.gap_y2),
      .o_pass(sp0.pass), .o_active(sp0.active));
   scroll_pipe #(.SPEED(78)) u_fast (
      .i_clk(clk), .i_rst_n(rst_n), .i_animate(sp1.animate), .i_run(sp1.run),
      .o_x1(sp1.x1), .o_x2(sp1.x2), .o_gap_y1(sp1.gap_y1), .o_gap_y2(sp1.gap_y2),
      .o_pass(sp1.pass), .o_active(sp1.active));
   int n_tests = 0, n_fail = 0;
   int spd[2] = '{2, 78};
   int m_xr[2], m_gy[2], m_mode[2], m_pass[2];
   logic [15:0] m_lfsr[2];
   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic int clip(input int v, input int hi);
      return v > hi ? hi : v;
   endfunction
   task automatic model_step(input int k, input logic rn, input logic r, input logic a);
      if (!rn) begin
         m_mode[k] = M_IDLE; m_xr[k] = 720; m_gy[k] = 240; m_pass[k] = 0; m_lfsr[k] = 16'hACE1;
         return;
      end
      m_pass[k] = 0;
      if (m_mode[k] == M_WRAP) begin
         m_gy[k] = RND ? (int'(m_lfsr[k] % 512) < 80 ? 80 : clip(int'(m_lfsr[k] % 512), 400)) : 240;
         m_mode[k] = M_RUN;
      end else if (m_mode[k] == M_RUN) begin
         if (!r) m_mode[k] = M_PAUSE;
         else if (a) begin
            if (m_xr[k] <= spd[k]) begin
               m_xr[k] = 720; m_mode[k] = M_WRAP;
            end else begin
               if (m_xr[k] >= 160 && m_xr[k] - spd[k] < 160) m_pass[k] = 1;
               m_xr[k] -= spd[k];
            end
         end
      end else if (r) m_mode[k] = M_RUN;
      m_lfsr[k] = {m_lfsr[k][14:0], m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
   endtask
   task automatic cmp_model(input int k, input int x1, input int x2, input int y1, input int y2,
                            input int p, input int act);
      check($sformatf("x1[%0d]", k), x1, m_xr[k] < 80 ? 0 : clip(m_xr[k] - 80, 640));
      check($sformatf("x2[%0d]", k), x2, clip(m_xr[k], 640));
      check($sformatf("gy1[%0d]", k), y1, m_gy[k] - 60);
      check($sformatf("gy2[%0d]", k), y2, m_gy[k] + 60);
      check($sformatf("pass[%0d]", k), p, m_pass[k]);
      check($sformatf("active[%0d]", k), act, int'(m_mode[k] == M_RUN));
   endtask
   task automatic cyc(input logic rn, input logic r, input logic a);
      rst_n = rn; sp0.run = r; sp0.animate = a; sp1.run = r; sp1.animate = a;
      @(posedge clk);
      model_step(0, rn, r, a);
      model_step(1, rn, r, a);
      #1;
      cmp_model(0, sp0.x1, sp0.x2, sp0.gap_y1, sp0.gap_y2, sp0.pass, sp0.active);
      cmp_model(1, sp1.x1, sp1.x2, sp1.gap_y1, sp1.gap_y2, sp1.pass, sp1.active);
   endtask
   int passes;
   task automatic strobe(input logic r);
      cyc(1'b1, r, 1'b1);
      passes += int'(sp0.pass);
      cyc(1'b1, r, 1'b0);
   endtask
   typedef struct {
      logic rn, r, a;
      int   x1, x2, act, pas;
   } vec_t;
   vec_t tv[9];
   initial begin
      int wraps, budget;
      tv[0] = '{1'b0, 1'b0, 1'b0, 640, 640, 0, 0};
      tv[1] = '{1'b1, 1'b0, 1'b1, 640, 640, 0, 0};
      tv[2] = '{1'b1, 1'b1, 1'b1, 640, 640, 1, 0};
      tv[3] = '{1'b1, 1'b1, 1'b1, 638, 640, 1, 0};
      tv[4] = '{1'b1, 1'b1, 1'b0, 638, 640, 1, 0};
      tv[5] = '{1'b1, 1'b0, 1'b1, 638, 640, 0, 0};
      tv[6] = '{1'b1, 1'b0, 1'b1, 638, 640, 0, 0};
      tv[7] = '{1'b1, 1'b1, 1'b1, 638, 640, 1, 0};
      tv[8] = '{1'b1, 1'b1, 1'b1, 636, 640, 1, 0};
      cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         cyc(tv[i].rn, tv[i].r, tv[i].a);
         check($sformatf("tv%0d_x1", i), sp0.x1, tv[i].x1);
         check($sformatf("tv%0d_x2", i), sp0.x2, tv[i].x2);
         check($sformatf("tv%0d_active", i), sp0.active, tv[i].act);
         check($sformatf("tv%0d_pass", i), sp0.pass, tv[i].pas);
      end
      // reset, idle strobes
      cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) strobe(1'b0);
      check("idle_x1", sp0.x1, 640);
      check("idle_x2", sp0.x2, 640);
      check("idle_active", sp0.active, 0);
      // scroll, score, wrap
      cyc(1'b1, 1'b1, 1'b0);
      passes = 0;
      for (int i = 0; i < 40; i++) strobe(1'b1);
      check("scroll_x1", sp0.x1, 560);
      check("scroll_x2", sp0.x2, 640);
      for (int i = 40; i < 280; i++) strobe(1'b1);
      check("pre_score_pass", passes, 0);
      cyc(1'b1, 1'b1, 1'b1);
      check("score_x2", sp0.x2, 158);
      check("score_pulse", sp0.pass, 1);
      cyc(1'b1, 1'b1, 1'b0);
      check("score_pulse_end", sp0.pass, 0);
      for (int i = 281; i < 359; i++) strobe(1'b1);
      check("score_once", passes, 0);
      check("prewrap_x2", sp0.x2, 2);
      check("prewrap_x1", sp0.x1, 0);
      cyc(1'b1, 1'b1, 1'b1);
      check("wrap_x2", sp0.x2, 640);
      check("wrap_x1", sp0.x1, 640);
      check("wrap_active", sp0.active, 0);
      check("wrap_pass", sp0.pass, 0);
      cyc(1'b1, 1'b1, 1'b0);
      check("postwrap_active", sp0.active, 1);
      check("postwrap_pass", sp0.pass, 0);
`ifndef SCROLL_PIPE_RANDOM_GAP_EN
      check("postwrap_gy1", sp0.gap_y1, 180);
      check("postwrap_gy2", sp0.gap_y2, 300);
`endif
      // pause and resume
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) strobe(1'b1);
      check("pause_start_x2", sp0.x2, 520);
      for (int i = 0; i < 50; i++) strobe(1'b0);
      check("paused_x2", sp0.x2, 520);
      check("paused_active", sp0.active, 0);
      cyc(1'b1, 1'b1, 1'b0);
      strobe(1'b1);
      check("resume_x2", sp0.x2, 518);
      // reset coincident with a wrapping strobe
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 359; i++) strobe(1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      check("rstwrap_active", sp0.active, 0);
      check("rstwrap_x1", sp0.x1, 640);
      check("rstwrap_gy1", sp0.gap_y1, 180);
      check("rstwrap_gy2", sp0.gap_y2, 300);
      check("rstwrap_pass", sp0.pass, 0);
      cyc(1'b1, 1'b0, 1'b0);
      check("rstwrap_idle", sp0.active, 0);
      // random stimulus
      for (int i = 0; i < 4000; i++)
         cyc(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 9) != 0),
             logic'($urandom_range(0, 2) == 0));
      // many wraps on the fast instance
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      wraps = 0;
      budget = 0;
      while (wraps < 1000 && budget < 15000) begin
         cyc(1'b1, 1'b1, 1'b1);
         budget++;
         if (m_mode[1] == M_WRAP) begin
            wraps++;
            cyc(1'b1, 1'b1, 1'b1);
            budget++;
            check("gap_range", int'(sp1.gap_y1 + 12'd60 >= 12'd80 && sp1.gap_y2 - 12'd60 <= 12'd400), 1);
         end
      end
      check("wrap_budget", int'(wraps >= 1000), 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/scroll_pipe.md
SCROLL_PIPE -- requirements
Module: scroll_pipe

Interface
REQ-001 SHALL have parameter X_SIZE, default 40: half pipe width in pixels.
REQ-002 SHALL have parameter GAP_SIZE, default 60: half gap height in pixels.
REQ-003 SHALL have parameter IX, default 720: initial right-edge position.
REQ-004 SHALL have parameter IY, default 240: initial gap centre.
REQ-005 SHALL have parameters D_WIDTH, default 640, and D_HEIGHT, default 480: display size.
REQ-006 SHALL have parameter SPEED, default 2: pixels moved per animate strobe.
REQ-007 SHALL have parameter SCORE_X, default 160: scoring column.
REQ-008 SHALL have parameter MARGIN, default 20: minimum gap distance from the top and bottom screen edges.
REQ-009 SHALL have parameter SEED, default 16'hACE1: LFSR reset value.
REQ-010 SHALL have ports, in order:
- i_clk, input, 1: base clock.
- i_rst_n, input, 1: synchronous active-low reset.
- i_animate, input, 1: frame strobe, one cycle wide.
- i_run, input, 1: motion enable.
- o_x1, o_x2, output, 12 each: clipped left and right edges.
- o_gap_y1, o_gap_y2, output, 12 each: gap top and bottom.
- o_pass, output, 1: score pulse.
- o_active, output, 1: state is RUN.

Function
REQ-011 SHALL hold a 12-bit right-edge register xr and a 12-bit gap-centre register gy.
REQ-012 SHALL drive the edge outputs as follows; all are combinational from registers:
- o_x1 = 0 when xr < 2*X_SIZE, otherwise min(xr-2*X_SIZE, D_WIDTH).
- o_x2 = min(xr, D_WIDTH).
- o_gap_y1 = gy-GAP_SIZE.
- o_gap_y2 = gy+GAP_SIZE.
REQ-013 SHALL implement states IDLE, RUN, PAUSE and WRAP.
REQ-014 SHALL make these transitions:
- IDLE or PAUSE -> RUN when i_run=1.
- RUN -> PAUSE when i_run=0.
- WRAP -> RUN after exactly one cycle, regardless of i_run.
REQ-015 SHALL move only in RUN, only when i_animate=1 and i_run=1:
- if xr <= SPEED, set xr <= D_WIDTH+2*X_SIZE and enter WRAP;
- otherwise set xr <= xr-SPEED.
REQ-016 SHALL ignore i_animate in IDLE, PAUSE and WRAP, including an i_animate in the same cycle as the IDLE->RUN transition.
REQ-017 SHALL load gy with a new gap centre in the WRAP cycle; gy SHALL be unchanged at all other times.
REQ-018 SHALL assert o_pass for exactly one cycle, in the cycle after a move where the old xr >= SCORE_X and the new xr < SCORE_X; a wrap never asserts o_pass.
REQ-019 SHALL make movement, wrap and o_pass visible on the outputs one cycle after the i_animate sample.
REQ-020 SHALL perform all arithmetic 12-bit unsigned; parameters SHALL satisfy D_WIDTH+2*X_SIZE < 4096 and SPEED < 2*X_SIZE.
REQ-021 SHALL hold o_active=1 exactly while the state is RUN.

Reset
REQ-022 SHALL, on i_rst_n=0 at a clock edge in any state including mid-wrap, set state IDLE, xr=IX, gy=IY, o_pass=0 and LFSR=SEED.
REQ-023 SHALL produce these post-reset outputs with defaults: o_x1=640, o_x2=640, o_gap_y1=180, o_gap_y2=300, o_pass=0, o_active=0.

Configuration
REQ-024 SHALL, with SCROLL_PIPE_RANDOM_GAP_EN defined, compute the new gap centre as follows:
- a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every clock out of reset;
- the WRAP load is gy <= clamp(LFSR[8:0], GAP_SIZE+MARGIN, D_HEIGHT-GAP_SIZE-MARGIN);
- with defaults the clamp range is [80,400].
REQ-025 SHALL, without SCROLL_PIPE_RANDOM_GAP_EN, omit the LFSR entirely, and the WRAP cycle SHALL reload gy <= IY.

Structure
REQ-026 SHALL take the state enumeration typedef and the display-size constants (640, 480, 12-bit coordinate width) from the shared package game_pkg.
REQ-027 SHALL place the LFSR in sub-module lfsr16, with ports i_clk, i_rst_n, a seed parameter and o_q[15:0], instantiated only under the macro.

Verification
REQ-028 SHALL pass a reset check: reset, i_run=0, 10 animate strobes -> xr=720, o_x1=640, o_x2=640, o_active=0.
REQ-029 SHALL pass a scroll check: i_run=1, then 40 strobes -> o_x1=560, o_x2=640; the 281st strobe gives xr=158 and exactly one o_pass pulse.
REQ-030 SHALL pass a wrap check with the macro off:
- the 360th strobe (at xr=2) gives xr=720;
- o_active=0 for one cycle, then 1;
- gap stays 180/300;
- no o_pass on the wrap.
REQ-031 SHALL pass a pause check: i_run=0 after 100 strobes -> xr frozen at 520 over 50 strobes; i_run=1 resumes at 518 on the next strobe.
REQ-032 SHALL pass a random-gap check with the macro on: 1000 wraps -> every gy in [80,400], matching an LFSR reference model seeded 16'hACE1.
REQ-033 SHALL pass a mid-operation reset check: i_rst_n=0 coincident with a wrapping strobe -> next cycle IDLE, xr=720, gy=240, o_pass=0.
